// File: rtl/dcache_controller.sv
// dcache_controller
//   Direct-mapped, write-back, write-allocate data cache between the CPU byte
//   load/store path and a 32-bit-block data memory. Hits are served with a
//   one-cycle stall and no memory traffic; misses stall the CPU through
//   busywait while a dirty victim is written back and the block is fetched.
//
// Ports
//   clock, reset          system clock, asynchronous active-high reset
//   read, write           CPU request (held until busywait low; both = write)
//   address, writedata    CPU byte address {tag, index, offset} and store data
//   readdata, busywait    CPU load data and stall
//   mem_read, mem_write   block fetch / write-back request (never both high)
//   mem_address           block address {tag, index}
//   mem_writedata         victim block, byte 0 in [7:0]
//   mem_readdata          fetched block
//   mem_busywait          memory busy; a request completes when it drops
//   hit_count, miss_count saturating request counters (DCACHE_STATS_EN only)
//
// Optional feature macro: DCACHE_STATS_EN

module dcache_controller #(
    parameter int unsigned INDEX_BITS  = 3,
    parameter int unsigned BLOCK_BYTES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    output logic        busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    localparam int unsigned OFFSET_BITS = $clog2(BLOCK_BYTES);
    localparam int unsigned TAG_BITS    = 6 - INDEX_BITS;
    localparam int unsigned NUM_BLOCKS  = 1 << INDEX_BITS;

    typedef enum logic [1:0] {StIdle, StWriteBack, StFetch, StUpdate} state_t;

    state_t r_state, w_next_state;

    logic [31:0]         r_data  [NUM_BLOCKS];
    logic [TAG_BITS-1:0] r_tag   [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] r_valid, r_dirty;

    logic r_mem_seen;   // memory has raised busywait during this dwell
    logic r_hit_done;   // hit serviced last cycle; busywait held low for one cycle

    logic [INDEX_BITS-1:0]  w_index;
    logic [TAG_BITS-1:0]    w_tag;
    logic [OFFSET_BITS-1:0] w_offset;
    logic                   w_req, w_hit, w_hit_service, w_miss_start;

    assign w_index  = address[OFFSET_BITS +: INDEX_BITS];
    assign w_tag    = address[7 -: TAG_BITS];
    assign w_offset = address[OFFSET_BITS-1:0];
    assign w_req    = read | write;
    assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);

    assign w_hit_service = (r_state == StIdle) && w_req && w_hit && !r_hit_done;
    assign w_miss_start  = (r_state == StIdle) && w_req && !w_hit;

    // busywait/readdata are combinational on the CPU request, so they are
    // forced low while reset is asserted even if the CPU still holds a request.
    assign busywait = !reset && ((r_state != StIdle) || (w_req && !r_hit_done));
    assign readdata = (!reset && read && !write && w_hit)
                      ? r_data[w_index][{w_offset, 3'b000} +: 8] : 8'h00;

    always_comb begin
        w_next_state  = r_state;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = 6'h00;
        mem_writedata = 32'h0;
        unique case (r_state)
            StIdle: begin
                if (w_miss_start) begin
                    w_next_state = (r_valid[w_index] && r_dirty[w_index])
                                   ? StWriteBack : StFetch;
                end
            end
            StWriteBack: begin
                mem_write     = 1'b1;
                mem_address   = {r_tag[w_index], w_index};
                mem_writedata = r_data[w_index];
                if (r_mem_seen && !mem_busywait) w_next_state = StFetch;
            end
            StFetch: begin
                mem_read    = 1'b1;
                mem_address = {w_tag, w_index};
                if (r_mem_seen && !mem_busywait) w_next_state = StUpdate;
            end
            StUpdate: begin
                w_next_state = StIdle;
            end
            default: begin
                w_next_state = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_mem_seen <= 1'b0;
            r_hit_done <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_hit_done <= w_hit_service;
            if (w_next_state != r_state) begin
                r_mem_seen <= 1'b0;
            end else if (mem_busywait && (r_state == StWriteBack || r_state == StFetch)) begin
                r_mem_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (r_state == StUpdate) begin
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
        end else if (w_hit_service && write) begin
            r_dirty[w_index] <= 1'b1;
        end
    end

    // Block data and tags need no reset; valid qualifies them.
    always_ff @(posedge clock) begin
        if (r_state == StUpdate) begin
            r_data[w_index] <= mem_readdata;
            r_tag[w_index]  <= w_tag;
        end else if (w_hit_service && write) begin
            r_data[w_index][{w_offset, 3'b000} +: 8] <= writedata;
        end
    end

`ifdef DCACHE_STATS_EN
    logic r_missed;   // current request already counted as a miss

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_missed   <= 1'b0;
            hit_count  <= 16'h0;
            miss_count <= 16'h0;
        end else begin
            if (w_miss_start) begin
                r_missed <= 1'b1;
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'h1;
            end else if (w_hit_service) begin
                r_missed <= 1'b0;
                if (!r_missed && hit_count != 16'hFFFF) hit_count <= hit_count + 16'h1;
            end
        end
    end
`endif

endmodule
